// File: rtl/sub_mul_pkg.sv
// Shared constants and types for the sub-multiply arbiter slice.
// Defaults here are the elaborated sizes used by the top and by its benches.
package sub_mul_pkg;

    localparam int DATAPATH_LATENCY = 3;
    localparam int NUM_REQ_DEF      = 4;
    localparam int WIDTH_DEF        = 16;
    localparam int FIFO_DEPTH_DEF   = 8;

    typedef logic [WIDTH_DEF-1:0]           operand_t;
    typedef logic [$clog2(NUM_REQ_DEF)-1:0] id_t;

endpackage

// File: rtl/sub_mul.sv
// Purpose: p = (d - a) * b, wrapping modulo 2^WIDTH.
// Latency: fixed DATAPATH_LATENCY (3) cycles, one new operand set per cycle.
// Backpressure: none; free-running with no enable, so the caller tracks validity.
module sub_mul
    import sub_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] p_q;

    // Datapath registers are deliberately unreset; validity lives in the caller.
    always_ff @(posedge clk) begin
        diff_q <= d - a;
        b_q    <= b;
        prod_q <= diff_q * b_q;
        p_q    <= prod_q;
    end

    assign p = p_q;

endmodule

// File: rtl/sub_mul_arbiter.sv
// Purpose: round-robin share of one sub_mul datapath among NUM_REQ requesters.
// Latency: handshake in cycle 0, result visible on rsp port in cycle 4 at the earliest.
// Backpressure: credit counter covers FIFO plus pipeline, so req_ready drops before overflow.
module sub_mul_arbiter
    import sub_mul_pkg::*;
#(
    parameter int  NUM_REQ    = NUM_REQ_DEF,
    parameter int  WIDTH      = WIDTH_DEF,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_d,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [WIDTH-1:0]              rsp_data
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int L  = DATAPATH_LATENCY;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] dat;
    } rsp_ent_t;

    logic [IDW-1:0]      last_gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_any;
    logic [CW-1:0]       credit;
    logic                issue;
    logic                pop;
    logic [L-1:0]        pipe_vld;
    logic [L-1:0][IDW-1:0] pipe_id;
    logic [WIDTH-1:0]    mul_p;
    rsp_ent_t            mem [FIFO_DEPTH];
    rsp_ent_t            head;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                fifo_push;
    logic                fifo_full;

    // Scan from last_gnt+1 upward; the first valid requester wins.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    assign issue     = gnt_any && (credit != '0) && !rst;
    assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= IDW'(NUM_REQ - 1);
            credit   <= CW'(FIFO_DEPTH);
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            if (issue) begin
                last_gnt <= gnt_idx;
            end
            if (issue && !pop) begin
                credit <= credit - 1'b1;
            end else if (pop && !issue) begin
                credit <= credit + 1'b1;
            end
            pipe_vld <= {pipe_vld[L-2:0], issue};
            pipe_id  <= {pipe_id[L-2:0], gnt_idx};
        end
    end

    sub_mul #(
        .WIDTH (WIDTH)
    ) u_sub_mul (
        .clk (clk),
        .a   (req_a[gnt_idx]),
        .b   (req_b[gnt_idx]),
        .d   (req_d[gnt_idx]),
        .p   (mul_p)
    );

    assign fifo_push = pipe_vld[L-1];
    assign fifo_full = (count == CW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= '{id: pipe_id[L-1], dat: mul_p};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (fifo_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !fifo_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !pop));

    // Empty FIFO masks the unreset storage so idle outputs read as zero.
    assign head      = mem[rd_ptr];
    assign rsp_valid = (count != '0);
    assign rsp_id    = rsp_valid ? head.id  : '0;
    assign rsp_data  = rsp_valid ? head.dat : '0;

endmodule

// File: tb/tb_sub_mul_arbiter.sv
// Directed bench for sub_mul_arbiter: latency, wrap-around, fairness,
// backpressure/credit edge and mid-operation reset.
module tb_sub_mul_arbiter;
    import sub_mul_pkg::*;

    logic                                clk;
    logic                                rst;
    logic [NUM_REQ_DEF-1:0]              req_valid;
    logic [NUM_REQ_DEF-1:0]              req_ready;
    logic [NUM_REQ_DEF-1:0][WIDTH_DEF-1:0] req_a;
    logic [NUM_REQ_DEF-1:0][WIDTH_DEF-1:0] req_b;
    logic [NUM_REQ_DEF-1:0][WIDTH_DEF-1:0] req_d;
    logic                                rsp_valid;
    logic                                rsp_ready;
    id_t                                 rsp_id;
    operand_t                            rsp_data;

    int checks = 0;
    int errors = 0;

    sub_mul_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] id, input logic [31:0] dat);
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), id);
        chk({tag, "_dat"}, 32'(rsp_data), dat);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_d     = '0;

        // Reset state with requests pending
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_vld", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_dat", 32'(rsp_data), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        tick();

        // Single request from requester 2: (10-3)*5 = 35
        req_valid = 4'b0100;
        req_a[2] = 16'd3; req_b[2] = 16'd5; req_d[2] = 16'd10;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'h0;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("single_early", 32'(rsp_valid), 32'h0);
            tick();
        end
        #1;
        chk_rsp("single", 32'd2, 32'd35);
        tick();
        chk("single_drain", 32'(rsp_valid), 32'h0);

        // Wrap-around: pointer at 2, so requester 1 then 3
        req_valid = 4'b0010;
        req_a[1] = 16'd10; req_b[1] = 16'd1; req_d[1] = 16'd3;
        #1;
        chk("wrap_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        req_a[3] = 16'd0; req_b[3] = 16'd2; req_d[3] = 16'h8000;
        #1;
        chk("wrap_ready3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'h0;
        tick();
        tick();
        chk_rsp("wrap_neg", 32'd1, 32'hFFF9);
        tick();
        chk_rsp("wrap_zero", 32'd3, 32'h0000);
        tick();
        chk("wrap_drain", 32'(rsp_valid), 32'h0);

        // Fairness: all valid, data = 100 - id
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 16'(i); req_b[i] = 16'd1; req_d[i] = 16'd100;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) req_valid = 4'h0;
            #1;
            if (k < 8) chk("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k >= 4) chk_rsp("fair_rsp", 32'((k - 4) % 4), 32'(100 - ((k - 4) % 4)));
            else chk("fair_early", 32'(rsp_valid), 32'h0);
            tick();
        end
        chk("fair_drain", 32'(rsp_valid), 32'h0);

        // Backpressure: data = (50 - id) * 2
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 16'(i); req_b[i] = 16'd2; req_d[i] = 16'd50;
        end
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("bp_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_stall", 32'(req_ready), 32'h0);
            tick();
        end
        #1;
        chk_rsp("bp_head", 32'd0, 32'd100);
        tick();
        chk_rsp("bp_hold", 32'd0, 32'd100);
        // Credit edge: credit 0, pop this cycle, request pending -> no issue yet
        rsp_ready = 1'b1;
        #1;
        chk("credit_edge", 32'(req_ready), 32'h0);
        tick();
        chk("credit_resume", 32'(req_ready), 32'b0001);
        chk_rsp("bp_rsp1", 32'd1, 32'd98);
        tick();
        req_valid = 4'h0;
        for (int k = 2; k < 8; k++) begin
            #1;
            chk_rsp("bp_rsp", 32'(k % 4), 32'(100 - 2 * (k % 4)));
            tick();
        end
        chk_rsp("bp_late", 32'd0, 32'd100);
        tick();
        chk("bp_drain", 32'(rsp_valid), 32'h0);

        // Reset with 3 in flight and 2 queued
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_queued", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_vld", 32'(rsp_valid), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_dat", 32'(rsp_data), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("post_rst_stale", 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 4'hF;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        for (int k = 1; k < 4; k++) tick();
        chk_rsp("post_rst_rsp", 32'd0, 32'd100);
        tick();
        chk("post_rst_drain", 32'(rsp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_mul_arbiter.md
SUB_MUL_ARBITER -- requirements
Module: sub_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4: number of requesters sharing the sub-multiply datapath.
REQ-002 Parameter WIDTH, 16: operand and result width.
REQ-003 Parameter FIFO_DEPTH, 8: result FIFO entries; SHALL be at least 5.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operation valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a, req_b, req_d  in  NUM_REQ x WIDTH each  operands of requester i.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  clog2(NUM_REQ)  index of the originating requester.
REQ-012 rsp_data  out  WIDTH  result.

Function
REQ-013 Result SHALL be ((d - a) * b) mod 2^WIDTH, computed in two's-complement wrap-around arithmetic.
REQ-014 Request handshake: req_valid[i] & req_ready[i] at a rising edge; operands captured at that edge.
REQ-015 Grant SHALL be round-robin: priority starts at (last granted + 1) mod NUM_REQ; only valid requesters are granted.
REQ-016 The last-granted pointer SHALL update only on a completed handshake.
REQ-017 req_ready[i] SHALL be high iff requester i is granted and credit > 0; it may depend combinationally on req_valid.
REQ-018 Credit = FIFO_DEPTH - (FIFO occupancy + operations in flight); issue decrements it; rsp handshake increments it; both in the same cycle leave it unchanged.
REQ-019 The datapath is a fixed 3-stage pipeline without enable; a parallel valid/id shift register of depth 3 SHALL track each issued operation.
REQ-020 Latency: handshake in cycle 0 -> result written to FIFO at the end of cycle 3 -> rsp_valid high in cycle 4 at the earliest.
REQ-021 Throughput: one issue per cycle sustained while rsp_ready stays high.
REQ-022 Results SHALL leave in issue order; rsp_id and rsp_data hold stable while rsp_valid & !rsp_ready.
REQ-023 FIFO full: no overflow is possible by construction; assertion on write-when-full.
REQ-024 FIFO empty: rsp_valid low; no bypass from the pipeline to the rsp port.
REQ-025 Simultaneous push and pop on a full or empty FIFO SHALL both succeed.
REQ-026 Requester dropping req_valid without handshake SHALL lose nothing and leave the pointer unchanged.

Reset
REQ-027 During rst: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
REQ-028 Reset state: FIFO empty, credit = FIFO_DEPTH, valid shift register cleared, last-granted = NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued results.
REQ-030 Unreset datapath registers SHALL never produce a rsp_valid.
REQ-031 Reset assertion is asynchronous; deassertion is consumed synchronously by the upstream reset bridge.

Structure
REQ-032 Package sub_mul_pkg SHALL hold DATAPATH_LATENCY = 3, the operand_t and id_t typedefs, and the default parameters.
REQ-033 The existing sub_mul block SHALL be instantiated once as the only datapath sub-module.
REQ-034 The arbiter, valid/id tracker, credit counter and result FIFO are local logic.

Verification
REQ-035 Single-request check: requester 2 issues a=3, b=5, d=10 in cycle 0 -> rsp_valid in cycle 4, rsp_data = 35, rsp_id = 2.
REQ-036 Wrap-around check: a=10, d=3, b=1 -> 0xFFF9; a=0, d=0x8000, b=2 -> 0x0000.
REQ-037 Fairness check: all four requesters valid for 8 cycles with rsp_ready = 1 -> grants 0,1,2,3,0,1,2,3; responses in the same id order.
REQ-038 Backpressure check: rsp_ready = 0 with continuous requests -> exactly 8 accepts, then req_ready = 0. Raising rsp_ready -> 8 in-order results, one per cycle. Credit returns -> issue resumes one cycle after the first pop.
REQ-039 Reset check: assert rst with 3 in flight and 2 queued -> outputs 0 immediately. After release: no stale rsp_valid, and the first grant goes to requester 0.
REQ-040 Credit-edge check: credit = 0, pop and a pending request in the same cycle -> credit stays 0 and no issue that cycle. Issue occurs the next cycle.
